// File: rtl/spi_slave.sv
// SPI target endpoint: SCLK, CS_n and MOSI are oversampled on i_clock. Supports all four
// CPOL/CPHA modes, MSB first, with a one-entry valid/ready TX buffer and a one-cycle RX strobe.
module spi_slave #(
  parameter int SPI_DATA_WIDTH = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_clock_polarity,
  input  logic                      i_clock_phase,
  input  logic [SPI_DATA_WIDTH-1:0] i_tx_data,
  input  logic                      i_tx_valid,
  output logic                      o_tx_ready,
  output logic [SPI_DATA_WIDTH-1:0] o_rx_data,
  output logic                      o_rx_valid,
  output logic                      o_tx_underrun,
  output logic                      o_frame_abort,
  output logic                      o_busy,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_clock,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  output logic                      o_spi_miso_oe
);

  localparam int W     = SPI_DATA_WIDTH;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;

  logic cs_n_sync;
  logic sclk_sync;
  logic mosi_sync;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [W-1:0]     tx_shift_q;
  logic [W-1:0]     rx_shift_q;
  logic [W-1:0]     buf_q;
  logic             buf_full_q;
  logic [W-1:0]     rx_data_q;
  logic             rx_valid_q;
  logic             underrun_q;
  logic             abort_q;
  logic             miso_q;

  logic             lead_edge;
  logic             trail_edge;
  logic             sample_edge;
  logic             shift_edge;
  logic [W-1:0]     tx_shift_d;
  logic [W-1:0]     rx_shift_d;
  logic [CNT_W-1:0] cnt_d;

  // MOSI shares the SCLK synchroniser depth so the sampled bit lines up with the edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_clock};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_prev_q <= sclk_sync;
    end
  end

  assign cs_n_sync = cs_sync_q[SYNC_STAGES-1];
  assign sclk_sync = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  assign lead_edge   = (sclk_prev_q == cpol_q) && (sclk_sync != cpol_q);
  assign trail_edge  = (sclk_prev_q != cpol_q) && (sclk_sync == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
  assign rx_shift_d = {rx_shift_q[W-2:0], mosi_sync};
  assign cnt_d      = cnt_q + CNT_ONE;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;

      if (i_tx_valid && !buf_full_q) begin
        buf_q      <= i_tx_data;
        buf_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (cs_n_sync) begin
            cpol_q <= i_clock_polarity;
            cpha_q <= i_clock_phase;
          end else begin
            state_q <= LOAD;
          end
        end

        LOAD: begin
          if (cs_n_sync) begin
            state_q <= IDLE;
          end else begin
            if (buf_full_q) begin
              tx_shift_q <= buf_q;
              miso_q     <= buf_q[W-1];
              buf_full_q <= 1'b0;
            end else begin
              tx_shift_q <= '0;
              miso_q     <= 1'b0;
              underrun_q <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end

        SHIFT: begin
          // A finished word wins over a simultaneous CS_n release.
          if (cnt_q == CNT_FULL) begin
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= LOAD;
          end else if (cs_n_sync) begin
            abort_q <= (cnt_q != '0);
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= rx_shift_d;
              cnt_q      <= cnt_d;
            end
            // With a zero count, CPHA=1 just re-drives the MSB and CPHA=0 ignores the
            // trailing edge left over from the previous frame.
            if (shift_edge) begin
              if (cnt_q == '0) begin
                if (cpha_q) begin
                  miso_q <= tx_shift_q[W-1];
                end
              end else begin
                tx_shift_q <= tx_shift_d;
                miso_q     <= tx_shift_q[W-2];
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_ready    = ~buf_full_q;
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_tx_underrun = underrun_q;
  assign o_frame_abort = abort_q;
  assign o_busy        = ~cs_n_sync;
  assign o_spi_miso    = miso_q;
  assign o_spi_miso_oe = ~cs_n_sync;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master drives frames in all modes while a queue-based
// reference model predicts RX words, MISO words and strobe counts; a monitor checks the strobes.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int H    = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_clock_polarity = 1'b0;
  logic         i_clock_phase = 1'b0;
  logic [W-1:0] i_tx_data = '0;
  logic         i_tx_valid = 1'b0;
  logic         o_tx_ready;
  logic [W-1:0] o_rx_data;
  logic         o_rx_valid;
  logic         o_tx_underrun;
  logic         o_frame_abort;
  logic         o_busy;
  logic         i_spi_cs_n = 1'b1;
  logic         i_spi_clock = 1'b0;
  logic         i_spi_mosi = 1'b0;
  logic         o_spi_miso;
  logic         o_spi_miso_oe;

  always #5 clk = ~clk;

  spi_slave #(.SPI_DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_clock_polarity (i_clock_polarity),
    .i_clock_phase    (i_clock_phase),
    .i_tx_data        (i_tx_data),
    .i_tx_valid       (i_tx_valid),
    .o_tx_ready       (o_tx_ready),
    .o_rx_data        (o_rx_data),
    .o_rx_valid       (o_rx_valid),
    .o_tx_underrun    (o_tx_underrun),
    .o_frame_abort    (o_frame_abort),
    .o_busy           (o_busy),
    .i_spi_cs_n       (i_spi_cs_n),
    .i_spi_clock      (i_spi_clock),
    .i_spi_mosi       (i_spi_mosi),
    .o_spi_miso       (o_spi_miso),
    .o_spi_miso_oe    (o_spi_miso_oe)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model state
  logic [W-1:0] model_buf[$];
  logic [W-1:0] exp_rx_q[$];
  int           exp_underrun = 0;
  int           exp_abort = 0;
  int           exp_ready_rise = 0;
  logic [W-1:0] last_rx = '0;
  logic         cpol = 1'b0;
  logic         cpha = 1'b0;

  // Monitor state
  int   obs_underrun = 0;
  int   obs_abort = 0;
  int   obs_ready_rise = 0;
  int   obs_rst_strobes = 0;
  logic ready_prev = 1'b1;
  int   cyc = 0;
  int   last_sample_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (o_rx_valid || o_tx_underrun || o_frame_abort) obs_rst_strobes++;
    end else begin
      if (o_rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          checks++;
          $display("FAIL rx_unexpected: rx_valid with data 0x%0h, no word expected", o_rx_data);
        end else begin
          logic [W-1:0] e;
          e = exp_rx_q.pop_front();
          check("rx_data", o_rx_data, e);
          check("rx_latency", cyc - last_sample_cyc, SYNC + 2);
          $display("rx word 0x%02h (expected 0x%02h)", o_rx_data, e);
        end
      end
      if (o_tx_underrun) obs_underrun++;
      if (o_frame_abort) obs_abort++;
    end
    if (o_tx_ready && !ready_prev) obs_ready_rise++;
    ready_prev = o_tx_ready;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each LOAD hands the buffered word to the shifter, or zeros with an underrun.
  function automatic logic [W-1:0] model_load();
    logic [W-1:0] w;
    if (model_buf.size() != 0) begin
      w = model_buf.pop_front();
      exp_ready_rise++;
    end else begin
      w = '0;
      exp_underrun++;
    end
    return w;
  endfunction

  task automatic tx_write(input logic [W-1:0] d);
    int n = 0;
    while (!o_tx_ready && n < 100) begin
      wait_cyc(1);
      n++;
    end
    check("tx_ready_wait", o_tx_ready, 1);
    if (o_tx_ready) begin
      i_tx_data  = d;
      i_tx_valid = 1'b1;
      wait_cyc(1);
      i_tx_valid = 1'b0;
      model_buf.push_back(d);
      check("tx_ready_drop", o_tx_ready, 0);
    end
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    i_clock_polarity = p;
    i_clock_phase = h;
    i_spi_clock = p;
    wait_cyc(8);
  endtask

  task automatic cs_low(output logic [W-1:0] w);
    i_spi_cs_n = 1'b0;
    w = model_load();
    wait_cyc(2 * H);
    check("busy_active", {o_busy, o_spi_miso_oe}, 2'b11);
  endtask

  // Bit-banged master; stops after max_edges SCLK edges to model an aborted frame.
  task automatic spi_xfer(input logic [W-1:0] mw, input int max_edges, output logic [W-1:0] rw);
    int e = 0;
    rw = '0;
    for (int b = W - 1; b >= 0; b--) begin
      if (!cpha) i_spi_mosi = mw[b];
      wait_cyc(H);
      if (e == max_edges) break;
      if (cpha) i_spi_mosi = mw[b];
      else begin
        rw = {rw[W-2:0], o_spi_miso};
        last_sample_cyc = cyc;
      end
      i_spi_clock = ~cpol;
      e++;
      wait_cyc(H);
      if (e == max_edges) break;
      if (cpha) begin
        rw = {rw[W-2:0], o_spi_miso};
        last_sample_cyc = cyc;
      end
      i_spi_clock = cpol;
      e++;
    end
    wait_cyc(H);
  endtask

  task automatic run_frame(input logic [W-1:0] mw, input logic [W-1:0] exp_miso,
                           output logic [W-1:0] next_w);
    logic [W-1:0] rw;
    exp_rx_q.push_back(mw);
    spi_xfer(mw, 2 * W, rw);
    check("miso_word", rw, exp_miso);
    $display("frame mode %0d mosi 0x%02h miso 0x%02h (expected 0x%02h)",
             {cpol, cpha}, mw, rw, exp_miso);
    last_rx = mw;
    next_w = model_load();
  endtask

  task automatic abort_frame(input logic [W-1:0] mw, input int edges);
    logic [W-1:0] rw;
    spi_xfer(mw, edges, rw);
    exp_abort++;
    $display("abort mode %0d after %0d edges", {cpol, cpha}, edges);
  endtask

  task automatic window_end();
    i_spi_cs_n = 1'b1;
    wait_cyc(4);
    i_spi_clock = cpol;
    wait_cyc(3 * H);
    check("underrun_count", obs_underrun, exp_underrun);
    check("abort_count", obs_abort, exp_abort);
    check("ready_rises", obs_ready_rise, exp_ready_rise);
    check("busy_idle", {o_busy, o_spi_miso_oe}, 2'b00);
    check("rx_hold", o_rx_data, last_rx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] nw;
    int           nf;
    logic [1:0]   md;

    // Reset state
    wait_cyc(3);
    check("rst_outputs", {o_tx_ready, o_busy, o_spi_miso_oe, o_spi_miso, o_rx_valid,
                          o_tx_underrun, o_frame_abort}, 7'b1000000);
    check("rst_rx_data", o_rx_data, 0);
    rst = 1'b0;
    wait_cyc(4);
    check("post_rst_outputs", {o_tx_ready, o_busy, o_spi_miso_oe, o_spi_miso}, 4'b1000);

    // Mode 0, TX 0xA5, MOSI 0x3C
    set_mode(1'b0, 1'b0);
    tx_write(8'hA5);
    cs_low(w);
    run_frame(8'h3C, w, nw);
    window_end();

    // Modes 1..3, TX 0x81, MOSI 0x7E
    for (int m = 1; m < 4; m++) begin
      md = 2'(m);
      set_mode(md[1], md[0]);
      tx_write(8'h81);
      cs_low(w);
      run_frame(8'h7E, w, nw);
      window_end();
    end

    // Back-to-back frames under one CS_n
    set_mode(1'b0, 1'b0);
    tx_write(8'h11);
    cs_low(w);
    tx_write(8'h22);
    run_frame(8'($urandom), w, nw);
    run_frame(8'($urandom), nw, w);
    window_end();

    // No TX word written
    cs_low(w);
    run_frame(8'hC3, w, nw);
    window_end();

    // CS_n released after 5 SCLK edges
    tx_write(8'h99);
    cs_low(w);
    abort_frame(8'hF0, 5);
    window_end();

    // Reset after 3 bits, then a clean 0x5A frame
    tx_write(8'h66);
    cs_low(w);
    spi_xfer(8'hE7, 6, nw);
    rst = 1'b1;
    wait_cyc(4);
    i_spi_cs_n = 1'b1;
    i_spi_clock = cpol;
    wait_cyc(4);
    check("rst_mid_outputs", {o_tx_ready, o_busy, o_rx_valid, o_tx_underrun, o_frame_abort},
          5'b10000);
    check("rst_mid_rx_data", o_rx_data, 0);
    rst = 1'b0;
    check("rst_strobes", obs_rst_strobes, 0);
    model_buf.delete();
    last_rx = '0;
    wait_cyc(8);
    tx_write(8'hB4);
    cs_low(w);
    run_frame(8'h5A, w, nw);
    window_end();

    // Randomised windows
    for (int it = 0; it < 30; it++) begin
      set_mode(1'($urandom), 1'($urandom));
      if (model_buf.size() == 0 && $urandom_range(0, 3) != 0) tx_write(8'($urandom));
      cs_low(w);
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        run_frame(8'($urandom), w, nw);
        w = nw;
        if (model_buf.size() == 0 && $urandom_range(0, 2) != 0) tx_write(8'($urandom));
      end
      if ($urandom_range(0, 4) == 0) abort_frame(8'($urandom), $urandom_range(2, 14));
      window_end();
    end

    check("rx_queue_empty", exp_rx_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
